cfg_stream_loader: RTL and testbench
====================================

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning the stream word width in bits.
REQ-002 The block SHALL have parameter CFG_W, default 871, meaning the total fabric configuration width (9+4+144+240+420+36+18 bits).
REQ-003 The block SHALL have derived constant NWORDS = ceil(CFG_W/WORD_W), which is 55 at the defaults.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port start, input, 1 bit: begin a load; sampled in IDLE or ERROR only.
REQ-007 Port abort, input, 1 bit: cancel the load in progress.
REQ-008 Port s_data, input, WORD_W bits: configuration stream word.
REQ-009 Port s_valid, input, 1 bit: s_data is valid.
REQ-010 Port s_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-011 Port cfg_out, output, CFG_W bits: committed configuration driving the fabric.
REQ-012 Port cfg_valid, output, 1 bit: at least one commit has succeeded since reset.
REQ-013 Port busy, output, 1 bit: state is not IDLE and not ERROR.
REQ-014 Port done, output, 1 bit: single-cycle commit pulse.
REQ-015 Port err, output, 1 bit: sticky load failure flag.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, CHECK, COMMIT and ERROR.
REQ-017 start in IDLE or ERROR SHALL move to LOAD, clear the word counter, shadow register and err; start in any other state SHALL be ignored.
REQ-018 s_ready SHALL equal (state==LOAD) && !abort, combinationally; a word SHALL be accepted only when s_valid && s_ready.
REQ-019 Accepted word k (0-based) SHALL be written to shadow bits [k*WORD_W +: WORD_W]; bits of the last word above CFG_W-1 SHALL be discarded.
REQ-020 On the edge accepting the final word, the state SHALL go LOAD->CHECK; gaps in s_valid SHALL stall without losing count.
REQ-021 CHECK SHALL last 1 cycle and go to COMMIT on pass, ERROR on fail.
REQ-022 Leaving COMMIT, cfg_out SHALL take the shadow value, cfg_valid and done SHALL be set, and the state SHALL go to IDLE; done SHALL clear on the following edge.
REQ-023 Latency: cfg_out and done SHALL update at the 2nd rising edge after the edge that accepted the final word.
REQ-024 cfg_out SHALL hold its previous value during LOAD, CHECK and ERROR, so reconfiguration is double-buffered.
REQ-025 abort in LOAD SHALL move to IDLE at the next edge, discard the shadow, and leave cfg_out, done and err unchanged; abort SHALL win over a simultaneous s_valid.
REQ-026 abort SHALL be ignored outside LOAD.
REQ-027 ERROR SHALL set err and hold it until start or reset.

Reset
REQ-028 While reset==0 at a rising edge, the state SHALL go to IDLE and the counter, shadow and cfg_out SHALL be set to 0.
REQ-029 While reset==0 at a rising edge, cfg_valid, done and err SHALL be set to 0; s_ready and busy SHALL therefore be 0.
REQ-030 Reset mid-load SHALL discard all progress, and reset SHALL take priority over start and abort.

Configuration
REQ-031 The block SHALL have macro CFG_LOADER_CRC_EN.
REQ-032 With CFG_LOADER_CRC_EN defined, LOAD SHALL accept NWORDS+1 words; the extra word is the CRC.
REQ-033 With CFG_LOADER_CRC_EN defined, a CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, MSB-first) SHALL be computed over the NWORDS data words as they are accepted.
REQ-034 With CFG_LOADER_CRC_EN defined, CHECK SHALL pass iff bits [15:0] of the CRC word equal the computed CRC, and WORD_W SHALL be >=16.
REQ-035 Without CFG_LOADER_CRC_EN, LOAD SHALL accept NWORDS words, CHECK SHALL always pass, and err SHALL be constant 0.

Verification
REQ-036 The bench SHALL drive reset=0 for 2 cycles, then reset=1 -> cfg_out=0, cfg_valid=0, busy=0, s_ready=0, done=0.
REQ-037 The bench SHALL pulse start, then send 55 words of 16'hA5A5 back-to-back (plus a correct CRC if CFG_LOADER_CRC_EN) -> 2 edges after the last word, cfg_out={A5A5 pattern}[870:0], done high for exactly 1 cycle, cfg_valid=1.
REQ-038 The bench SHALL send the same stream with s_valid toggling 1,0,0,1,... -> identical cfg_out, and only handshaked words counted.
REQ-039 The bench SHALL commit pattern 16'h1234, then load 16'hFFFF and assert abort after 20 words -> busy=0 next edge, cfg_out still the 16'h1234 pattern, no done pulse.
REQ-040 With CFG_LOADER_CRC_EN, the bench SHALL send a CRC word equal to the correct CRC XOR 16'h0001 -> err=1, no done, cfg_out unchanged; a following start -> err=0, busy=1.
REQ-041 The bench SHALL assert reset=0 after 30 accepted words -> state IDLE, cfg_out=0, cfg_valid=0 at the next edge.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// Streams NWORDS configuration words into a shadow register and commits them to cfg_out atomically.
// Define CFG_LOADER_CRC_EN to require a trailing CRC-16-CCITT word before a commit is allowed.
module cfg_stream_loader #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CFG_W  = 871
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [CFG_W-1:0]  cfg_out,
  output logic              cfg_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
`ifdef CFG_LOADER_CRC_EN
  localparam int unsigned NTOTAL = NWORDS + 1;
`else
  localparam int unsigned NTOTAL = NWORDS;
`endif
  localparam int unsigned CNT_W = $clog2(NTOTAL + 1);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NTOTAL - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StCommit, StError} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] shadow_d;
  logic             accept;
  logic             check_pass;
  logic             start_ok;

  assign s_ready  = (state_q == StLoad) && !abort;
  assign accept   = s_valid && s_ready;
  assign busy     = (state_q != StIdle) && (state_q != StError);
  assign start_ok = start && ((state_q == StIdle) || (state_q == StError));

  // Merge the incoming word into its slot; bits of the last word past CFG_W-1 have no slot.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned b = 0; b < CFG_W; b++) begin
      if (cnt_q == CNT_W'(b / WORD_W)) shadow_d[b] = s_data[b % WORD_W];
    end
  end

`ifdef CFG_LOADER_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_word_q;

  // MSB-first CRC-16-CCITT over one full stream word.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                           input logic [WORD_W-1:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign check_pass = (crc_word_q == crc_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q      <= 16'hFFFF;
      crc_word_q <= '0;
      err        <= 1'b0;
    end else if (start_ok) begin
      crc_q <= 16'hFFFF;
      err   <= 1'b0;
    end else if (accept) begin
      if (cnt_q == LastIdx) crc_word_q <= s_data[15:0];
      else                  crc_q      <= crc_step(crc_q, s_data);
    end else if ((state_q == StCheck) && !check_pass) begin
      err <= 1'b1;
    end
  end
`else
  assign check_pass = 1'b1;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StError: begin
          if (start) begin
            state_q  <= StLoad;
            cnt_q    <= '0;
            shadow_q <= '0;
          end
        end
        StLoad: begin
          if (abort) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
          end else if (accept) begin
            shadow_q <= shadow_d;
            if (cnt_q == LastIdx) state_q <= StCheck;
            else                  cnt_q   <= cnt_q + 1'b1;
          end
        end
        StCheck:  state_q <= check_pass ? StCommit : StError;
        StCommit: begin
          cfg_out   <= shadow_q;
          cfg_valid <= 1'b1;
          done      <= 1'b1;
          state_q   <= StIdle;
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader; the reference model packs the word list into the
// expected configuration image and, with CFG_LOADER_CRC_EN, computes the expected trailer CRC.
module tb_cfg_stream_loader;

  localparam int WORD_W = 16;
  localparam int CFG_W  = 871;
  localparam int NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
`ifdef CFG_LOADER_CRC_EN
  localparam int NTOTAL = NWORDS + 1;
`else
  localparam int NTOTAL = NWORDS;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [CFG_W-1:0]  cfg_out;
  logic              cfg_valid;
  logic              busy;
  logic              done;
  logic              err;

  int n_pass   = 0;
  int n_checks = 0;

  logic [WORD_W-1:0] words [NWORDS];
  logic [CFG_W-1:0]  committed;

  always #5 clk = ~clk;

  cfg_stream_loader #(.WORD_W(WORD_W), .CFG_W(CFG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Word k lands at bits [k*WORD_W +: WORD_W]; the image is then cut to CFG_W bits.
  function automatic logic [CFG_W-1:0] pack_words();
    logic [NWORDS*WORD_W-1:0] full;
    for (int k = 0; k < NWORDS; k++) full[k*WORD_W +: WORD_W] = words[k];
    return full[CFG_W-1:0];
  endfunction

  function automatic logic [15:0] crc_model();
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int k = 0; k < NWORDS; k++) begin
      for (int i = WORD_W - 1; i >= 0; i--) begin
        fb = r[15] ^ words[k][i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  task automatic set_words(input bit rand_mode, input logic [WORD_W-1:0] pat);
    for (int k = 0; k < NWORDS; k++) words[k] = rand_mode ? WORD_W'($urandom) : pat;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,..., 2 random valid.
  task automatic send_stream(input int gap_mode, input logic [15:0] crc_word,
                             input bit poke_start);
    int k   = 0;
    int cyc = 0;
    int bad = 0;
    bit v;
    while (k < NTOTAL && cyc < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = (k < NWORDS) ? words[k] : WORD_W'(crc_word);
      start   = poke_start && (k == 10);
      #1;
      if (s_ready !== 1'b1 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      if (v) k++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    n_checks++;
    if (k != NTOTAL) $display("FAIL stream_words: sent %0d want %0d", k, NTOTAL);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL load_ready: %0d cycles not ready/busy, want 0", bad);
    else n_pass++;
  endtask

  // Called one edge after the final accepted word; commit lands two edges after that word.
  task automatic expect_commit(input logic [CFG_W-1:0] expv, input bit abort_late);
    abort = abort_late;
    n_checks++;
    if (done !== 1'b0 || cfg_out !== committed)
      $display("FAIL commit_hold1: done=%b cfg_out=%h want done=0 cfg_out=%h",
               done, cfg_out, committed);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || cfg_out !== committed || busy !== 1'b1)
      $display("FAIL commit_hold2: done=%b busy=%b want 0/1", done, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || cfg_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL commit_flags: done=%b cfg_valid=%b busy=%b want 1/1/0",
               done, cfg_valid, busy);
    else n_pass++;
    n_checks++;
    if (cfg_out !== expv) $display("FAIL commit_data: got %h want %h", cfg_out, expv);
    else n_pass++;
    committed = expv;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_out !== committed)
      $display("FAIL done_pulse: done=%b busy=%b want 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_checks++;
    if (cfg_out !== '0) $display("FAIL reset_cfg_out: got %h want 0", cfg_out);
    else n_pass++;
    n_checks++;
    if ({cfg_valid, busy, s_ready, done, err} !== 5'b0)
      $display("FAIL reset_flags: cfg_valid/busy/s_ready/done/err=%b want 00000",
               {cfg_valid, busy, s_ready, done, err});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    set_words(1'b0, 16'hA5A5);
    pulse_start();
    send_stream(0, crc_model(), 1'b0);
    expect_commit(pack_words(), 1'b0);
  endtask

  task automatic test_gapped();
    set_words(1'b0, 16'hA5A5);
    pulse_start();
    send_stream(1, crc_model(), 1'b0);
    expect_commit(pack_words(), 1'b0);
  endtask

  // Random data, random valid gaps, a start inside LOAD and abort during CHECK/COMMIT.
  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      set_words(1'b1, '0);
      pulse_start();
      send_stream(2, crc_model(), 1'b1);
      expect_commit(pack_words(), 1'b1);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    set_words(1'b0, 16'h1234);
    pulse_start();
    send_stream(0, crc_model(), 1'b0);
    expect_commit(pack_words(), 1'b0);
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      s_data  = 16'hFFFF;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", s_ready);
    else n_pass++;
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cfg_out !== committed || err !== 1'b0)
      $display("FAIL abort_state: busy=%b err=%b cfg_out=%h want 0/0 %h",
               busy, err, cfg_out, committed);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      if (done !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0 || cfg_out !== committed)
      $display("FAIL abort_no_done: %0d done cycles, want 0", seen);
    else n_pass++;
  endtask

`ifdef CFG_LOADER_CRC_EN
  task automatic test_crc_error();
    set_words(1'b1, '0);
    pulse_start();
    send_stream(0, crc_model() ^ 16'h0001, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL crc_err: err=%b busy=%b done=%b want 1/0/0", err, busy, done);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || cfg_out !== committed)
      $display("FAIL crc_hold: err=%b done=%b cfg_out=%h want 1/0 %h",
               err, done, cfg_out, committed);
    else n_pass++;
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1)
      $display("FAIL crc_restart: err=%b busy=%b want 0/1", err, busy);
    else n_pass++;
    send_stream(2, crc_model(), 1'b0);
    expect_commit(pack_words(), 1'b0);
  endtask
`endif

  task automatic test_reset_midload();
    set_words(1'b1, '0);
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      s_valid = 1'b1;
      s_data  = words[k];
      @(posedge clk); #1;
    end
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || cfg_out !== '0 || cfg_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL midload_reset: busy=%b cfg_valid=%b done=%b cfg_out=%h want 0/0/0 0",
               busy, cfg_valid, done, cfg_out);
    else n_pass++;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    committed = '0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) $display("FAIL post_reset_idle: busy=%b want 0", busy);
    else n_pass++;
    set_words(1'b1, '0);
    pulse_start();
    send_stream(0, crc_model(), 1'b0);
    expect_commit(pack_words(), 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    committed = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_random();
    test_abort();
`ifdef CFG_LOADER_CRC_EN
    test_crc_error();
`endif
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
